// File: rtl/srb_pkg.sv
// Shared types and helpers for the sparse read buffer allocation side.
package srb_pkg;

    localparam int unsigned SRB_DEPTH_DFLT = 8;
    localparam int unsigned SRB_PTR_W_DFLT = $clog2(SRB_DEPTH_DFLT);

    typedef logic [SRB_PTR_W_DFLT-1:0] srb_idx_t;

    typedef struct packed {
        logic     wrap;
        srb_idx_t idx;
    } srb_ptr_t;

    // Pointers carry a wrap bit above the index, so the distance is taken modulo 2^(ptr_w+1).
    function automatic logic [31:0] srb_occupancy(
        input logic [31:0] w_ptr,
        input logic [31:0] btm_ptr,
        input int unsigned ptr_w
    );
        logic [31:0] mask;
        mask = (32'd1 << (ptr_w + 1)) - 32'd1;
        return (w_ptr - btm_ptr) & mask;
    endfunction

endpackage

// File: rtl/srb_alloc_ctrl_first_valid.sv
// Rotating priority finder: first set bit of i_vec at or after i_start, wrapping at the top.
module srb_first_valid #(
    parameter int unsigned SRB_DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(SRB_DEPTH)
) (
    input  logic [SRB_DEPTH-1:0] i_vec,
    input  logic [PTR_W-1:0]     i_start,
    output logic                 o_found,
    output logic [PTR_W-1:0]     o_idx,
    output logic                 o_wrapped
);

    logic [PTR_W-1:0] w_pos;

    // Scan from the farthest offset down so the nearest hit is the last one written.
    always_comb begin
        o_found   = 1'b0;
        o_idx     = i_start;
        o_wrapped = 1'b0;
        w_pos     = '0;
        for (int unsigned k = SRB_DEPTH; k > 0; k--) begin
            w_pos = i_start + PTR_W'(k - 1);
            if (i_vec[w_pos]) begin
                o_found   = 1'b1;
                o_idx     = w_pos;
                o_wrapped = (w_pos < i_start);
            end
        end
    end

endmodule

// File: rtl/srb_alloc_ctrl.sv
// SRB write/allocate side: in-order allocation, out-of-order release, in-order reclaim.
module srb_alloc_ctrl
    import srb_pkg::*;
#(
    parameter int unsigned SRB_DEPTH = SRB_DEPTH_DFLT,
    parameter int unsigned DATA_W    = 32,
    localparam int unsigned PTR_W    = $clog2(SRB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    output logic                 alloc_ready,
    input  logic [DATA_W-1:0]    alloc_data,
    output logic [PTR_W-1:0]     alloc_ptr,
    input  logic                 rel_valid,
    input  logic [PTR_W-1:0]     rel_ptr,
    output logic [DATA_W-1:0]    rel_data,
    output logic                 rel_err,
    output logic [SRB_DEPTH-1:0] entry_valid,
    output logic [PTR_W-1:0]     bottom_ptr,
    output logic [PTR_W:0]       occupancy,
    output logic                 full,
    output logic                 empty
);

    typedef struct packed {
        logic             wrap;
        logic [PTR_W-1:0] idx;
    } ptr_t;

    ptr_t                  r_w_ptr;
    ptr_t                  r_btm_ptr;
    logic [SRB_DEPTH-1:0]  r_entry_valid;
    logic [DATA_W-1:0]     r_mem [SRB_DEPTH];
    logic                  r_rel_err;

    logic                  w_full;
    logic                  w_alloc_fire;
    logic                  w_rel_ok;
    logic [SRB_DEPTH-1:0]  w_rel_mask;
    logic [SRB_DEPTH-1:0]  w_ev_r;
    logic                  w_found;
    logic [PTR_W-1:0]      w_found_idx;
    logic                  w_found_wrapped;
    ptr_t                  w_btm_nxt;

    assign w_full       = (r_w_ptr.idx == r_btm_ptr.idx) && (r_w_ptr.wrap != r_btm_ptr.wrap);
    assign w_alloc_fire = alloc_valid && !w_full;
    assign w_rel_ok     = rel_valid && r_entry_valid[rel_ptr];

    always_comb begin
        w_rel_mask = '0;
        if (w_rel_ok) begin
            w_rel_mask[rel_ptr] = 1'b1;
        end
    end

    // Bottom search sees registered valids minus this cycle's release; new allocations excluded.
    assign w_ev_r = r_entry_valid & ~w_rel_mask;

    srb_first_valid #(
        .SRB_DEPTH (SRB_DEPTH)
    ) u_first_valid (
        .i_vec     (w_ev_r),
        .i_start   (r_btm_ptr.idx),
        .o_found   (w_found),
        .o_idx     (w_found_idx),
        .o_wrapped (w_found_wrapped)
    );

    always_comb begin
        w_btm_nxt = r_w_ptr;
        if (w_found) begin
            w_btm_nxt.wrap = r_btm_ptr.wrap ^ w_found_wrapped;
            w_btm_nxt.idx  = w_found_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_ptr       <= '0;
            r_btm_ptr     <= '0;
            r_entry_valid <= '0;
            r_rel_err     <= 1'b0;
        end else begin
            r_rel_err <= rel_valid && !r_entry_valid[rel_ptr];
            if (w_alloc_fire) begin
                r_w_ptr <= ptr_t'(r_w_ptr + 1'b1);
            end
            if (w_rel_ok && (rel_ptr == r_btm_ptr.idx)) begin
                r_btm_ptr <= w_btm_nxt;
            end
            // The write slot is never valid, so set and clear never hit the same bit.
            r_entry_valid <= (r_entry_valid & ~w_rel_mask)
                           | (w_alloc_fire ? (SRB_DEPTH'(1) << r_w_ptr.idx) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_alloc_fire) begin
            r_mem[r_w_ptr.idx] <= alloc_data;
        end
    end

    assign alloc_ready = !w_full;
    assign alloc_ptr   = r_w_ptr.idx;
    assign rel_data    = r_mem[rel_ptr];
    assign rel_err     = r_rel_err;
    assign entry_valid = r_entry_valid;
    assign bottom_ptr  = r_btm_ptr.idx;
    assign occupancy   = (PTR_W + 1)'(srb_occupancy(32'(r_w_ptr), 32'(r_btm_ptr), PTR_W));
    assign full        = w_full;
    assign empty       = (r_w_ptr == r_btm_ptr);

endmodule

// File: tb/tb_srb_alloc_ctrl.sv
// Bench for srb_alloc_ctrl: directed scenarios plus random traffic against a count-based model.
module tb_srb_alloc_ctrl;

    localparam int unsigned D  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, alloc_valid, alloc_ready, rel_valid, rel_err, full, empty;
    logic [DW-1:0] alloc_data, rel_data;
    logic [PW-1:0] alloc_ptr, rel_ptr, bottom_ptr;
    logic [D-1:0]  entry_valid;
    logic [PW:0]   occupancy;

    srb_alloc_ctrl #(
        .SRB_DEPTH (D),
        .DATA_W    (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_data  (alloc_data),
        .alloc_ptr   (alloc_ptr),
        .rel_valid   (rel_valid),
        .rel_ptr     (rel_ptr),
        .rel_data    (rel_data),
        .rel_err     (rel_err),
        .entry_valid (entry_valid),
        .bottom_ptr  (bottom_ptr),
        .occupancy   (occupancy),
        .full        (full),
        .empty       (empty)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model: unbounded allocation/bottom counters; slot = count mod D.
    int unsigned   m_w, m_b;
    bit            m_v [D];
    logic [DW-1:0] m_mem [D];
    bit            m_err;
    bit            m_known = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        logic [D-1:0] ev;
        int unsigned  occ;
        occ = m_w - m_b;
        for (int i = 0; i < D; i++) ev[i] = m_v[i];
        check_eq("entry_valid", 64'(entry_valid), 64'(ev));
        check_eq("bottom_ptr", 64'(bottom_ptr), 64'(m_b % D));
        check_eq("alloc_ptr", 64'(alloc_ptr), 64'(m_w % D));
        check_eq("occupancy", 64'(occupancy), 64'(occ));
        check_eq("full", 64'(full), 64'(occ == D));
        check_eq("empty", 64'(empty), 64'(occ == 0));
        check_eq("alloc_ready", 64'(alloc_ready), 64'(occ != D));
        check_eq("rel_err", 64'(rel_err), 64'(m_err));
        if (m_v[rel_ptr]) check_eq("rel_data", 64'(rel_data), 64'(m_mem[rel_ptr]));
    endtask

    task automatic model_step(input bit av, input logic [DW-1:0] ad, input bit rv,
                              input logic [PW-1:0] rp, input bit r);
        bit          fire, relok;
        int unsigned old_w;
        if (r) begin
            m_w = 0; m_b = 0; m_err = 0; m_known = 1'b1;
            for (int i = 0; i < D; i++) m_v[i] = 0;
            return;
        end
        fire  = av && ((m_w - m_b) < D);
        relok = rv && m_v[rp];
        m_err = rv && !m_v[rp];
        old_w = m_w;
        if (relok) begin
            m_v[rp] = 0;
            if (int'(rp) == int'(m_b % D)) begin
                while (m_b < old_w && !m_v[m_b % D]) m_b++;
            end
        end
        if (fire) begin
            m_mem[m_w % D] = ad;
            m_v[m_w % D]   = 1;
            m_w++;
        end
    endtask

    task automatic cycle(input bit av, input logic [DW-1:0] ad, input bit rv,
                         input logic [PW-1:0] rp, input bit r);
        rst = r; alloc_valid = av; alloc_data = ad; rel_valid = rv; rel_ptr = rp;
        #1;
        if (m_known) check_outputs();
        @(posedge clk);
        model_step(av, ad, rv, rp, r);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; alloc_valid = 1'b0; alloc_data = '0; rel_valid = 1'b0; rel_ptr = '0;
        @(negedge clk);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Fill to full
        for (int i = 0; i < 4; i++) cycle(1, $urandom, 0, 0, 0);
        check_eq("t1_full", 64'(full), 64'd1);
        check_eq("t1_ready", 64'(alloc_ready), 64'd0);
        check_eq("t1_occ", 64'(occupancy), 64'd4);
        check_eq("t1_ev", 64'(entry_valid), 64'hf);

        // Out-of-order release leaves holes until the bottom is released
        cycle(0, 0, 1, 2, 0);
        cycle(0, 0, 1, 1, 0);
        check_eq("t2_btm_hold", 64'(bottom_ptr), 64'd0);
        check_eq("t2_full_hold", 64'(full), 64'd1);
        cycle(0, 0, 1, 0, 0);
        check_eq("t2_btm", 64'(bottom_ptr), 64'd3);
        check_eq("t2_occ", 64'(occupancy), 64'd1);
        check_eq("t2_ready", 64'(alloc_ready), 64'd1);

        // Release while full does not unblock the same-cycle allocation
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, $urandom, 0, 0, 0);
        cycle(1, $urandom, 1, 0, 0);
        check_eq("t3_occ_after_rel", 64'(occupancy), 64'd3);
        check_eq("t3_aptr", 64'(alloc_ptr), 64'd0);
        cycle(1, $urandom, 0, 0, 0);
        check_eq("t3_occ_refill", 64'(occupancy), 64'd4);

        // Sole entry released while a new one lands
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, $urandom, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(1, $urandom, 1, 2, 0);
        check_eq("t4_btm", 64'(bottom_ptr), 64'd3);
        check_eq("t4_ev", 64'(entry_valid), 64'h8);
        check_eq("t4_occ", 64'(occupancy), 64'd1);
        check_eq("t4_empty", 64'(empty), 64'd0);

        // Invalid release: one-cycle error pulse, no state change
        cycle(0, 0, 1, 1, 0);
        check_eq("t5_err", 64'(rel_err), 64'd1);
        check_eq("t5_ev", 64'(entry_valid), 64'h8);
        cycle(0, 0, 0, 0, 0);
        check_eq("t5_err_clr", 64'(rel_err), 64'd0);

        // In-order alloc/release stream wrapping the pointers twice
        cycle(0, 0, 0, 0, 1);
        cycle(1, $urandom, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            cycle(1, $urandom, 1, PW'(k - 1), 0);
            check_eq("t6_occ_le1", 64'(occupancy <= 1), 64'd1);
        end
        cycle(1, $urandom, 1, 2, 1);
        check_eq("t6_rst_ev", 64'(entry_valid), 64'd0);
        check_eq("t6_rst_empty", 64'(empty), 64'd1);
        check_eq("t6_rst_btm", 64'(bottom_ptr), 64'd0);

        // Random traffic, releases biased toward valid slots
        for (int n = 0; n < 400; n++) begin
            logic [PW-1:0] rp;
            rp = PW'($urandom_range(D - 1));
            if ($urandom_range(3) != 0) begin
                for (int t = 0; t < 4 && !m_v[rp]; t++) rp = PW'($urandom_range(D - 1));
            end
            cycle($urandom_range(3) != 0, $urandom, $urandom_range(4) < 3, rp,
                  $urandom_range(99) == 0);
        end
        cycle(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
